// File: rtl/mfp_ahb_tone_synth.sv
// -----------------------------------------------------------------------------
// mfp_ahb_tone_synth
//
// Multi-channel square-wave tone synthesiser on the AHB-Lite peripheral bus.
// Each channel has a half-period, a duration (in ms ticks) and a volume.
// Software programs these registers and then starts a note. All playing
// channels are summed and the sum drives a single PWM stream that feeds the
// board's 1-bit audio output.
//
// Register map: HADDR = {ch[1:0], reg[1:0]}
//   reg 0 PERIOD   RW  half-period in HCLK cycles (0 = rest note)
//   reg 1 DURATION RW  note length in ticks (0 = play until stopped)
//   reg 2 VOLUME   RW  mixer weight of the channel while its square is high
//   reg 3 CTRL     W: bit0 = start, bit1 = stop (stop wins)  R: bit0 = busy
// Channels at or above NUM_CH ignore writes and read as 0.
//
// Optional build macro:
//   MFP_AUDIO_ENVELOPE_EN  Each playing channel loses one volume step per tick,
//                          saturating at 0. VOLUME reads return the live value.
//
// Ports:
//   HCLK                      sole clock (25 MHz)
//   HRESETn                   synchronous active-low reset
//   HADDR[3:0]                register address {ch, reg}
//   HTRANS[1:0]               AHB transfer type
//   HWDATA[31:0]              write data, valid in the data phase
//   HWRITE                    write/read select
//   HSEL                      peripheral select
//   HRDATA[31:0]              registered read data
//   OUT_audio_pwm_and_enable  [0] = AUD_PWM, [1] = AUD_SD (amplifier enable)
// -----------------------------------------------------------------------------
module mfp_ahb_tone_synth #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 16,
    parameter int DUR_W    = 16,
    parameter int PWM_W    = 8,
    parameter int TICK_DIV = 25000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [3:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic [1:0]  OUT_audio_pwm_and_enable
);

    // Mixer width: four channels at full volume fit without overflow.
    localparam int S      = PWM_W + 2;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] HTRANS_IDLE  = 2'b00;
    localparam logic [1:0] REG_PERIOD   = 2'd0;
    localparam logic [1:0] REG_DURATION = 2'd1;
    localparam logic [1:0] REG_VOLUME   = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PLAY = 1'b1
    } ch_state_t;

    // -------------------------------------------------------------------------
    // AHB address phase capture. The write itself happens in the data phase,
    // one cycle later, when HWDATA is valid.
    // -------------------------------------------------------------------------
    logic [3:0] addr_d;
    logic [1:0] trans_d;
    logic       write_d;
    logic       sel_d;

    always_ff @(posedge HCLK) begin
        // NOTE: sequential state always uses non-blocking assignments so that
        // every register samples the values from before this clock edge.
        if (!HRESETn) begin
            addr_d  <= '0;
            trans_d <= HTRANS_IDLE;
            write_d <= 1'b0;
            sel_d   <= 1'b0;
        end else begin
            addr_d  <= HADDR;
            trans_d <= HTRANS;
            write_d <= HWRITE;
            sel_d   <= HSEL;
        end
    end

    logic       wr_en;
    logic       wr_hit;
    logic [1:0] wr_ch;
    logic [1:0] wr_reg;

    assign wr_en  = (trans_d != HTRANS_IDLE) && sel_d && write_d;
    assign wr_ch  = addr_d[3:2];
    assign wr_reg = addr_d[1:0];
    assign wr_hit = wr_en && (int'(wr_ch) < NUM_CH);

    // Only the low bits of HWDATA are stored; fold the rest away explicitly.
    logic unused_hwdata;
    assign unused_hwdata = ^HWDATA;

    // -------------------------------------------------------------------------
    // Duration tick prescaler (free running, never realigned on note start).
    // -------------------------------------------------------------------------
    logic [TICK_W-1:0] presc_q;
    logic              tick;

    assign tick = (presc_q == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + TICK_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Programmable channel registers.
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] period_q   [NUM_CH];
    logic [DUR_W-1:0] duration_q [NUM_CH];
    logic [PWM_W-1:0] volume_q   [NUM_CH];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            // NOTE: these register arrays are small flop banks that software
            // may read before ever writing, so every entry is reset; a RAM
            // would not be reset this way.
            for (int c = 0; c < NUM_CH; c++) begin
                period_q[c]   <= '0;
                duration_q[c] <= '0;
                volume_q[c]   <= '0;
            end
        end else if (wr_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (int'(wr_ch) == c) begin
                    case (wr_reg)
                        REG_PERIOD:   period_q[c]   <= HWDATA[DIV_W-1:0];
                        REG_DURATION: duration_q[c] <= HWDATA[DUR_W-1:0];
                        REG_VOLUME:   volume_q[c]   <= HWDATA[PWM_W-1:0];
                        default:      ;  // CTRL is a command, not storage
                    endcase
                end
            end
        end
    end

    // Start/stop commands decoded from a CTRL write; stop overrides start.
    logic [NUM_CH-1:0] start_req;
    logic [NUM_CH-1:0] stop_req;

    always_comb begin
        start_req = '0;
        stop_req  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_hit && (int'(wr_ch) == c) && (wr_reg == REG_CTRL)) begin
                stop_req[c]  = HWDATA[1];
                start_req[c] = HWDATA[0] && !HWDATA[1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel note FSM with half-period and duration counters.
    // -------------------------------------------------------------------------
    ch_state_t        state_q  [NUM_CH];
    ch_state_t        state_d  [NUM_CH];
    logic [DIV_W-1:0] half_q   [NUM_CH];
    logic [DIV_W-1:0] half_d   [NUM_CH];
    logic [DUR_W-1:0] dur_q    [NUM_CH];
    logic [DUR_W-1:0] dur_d    [NUM_CH];
    logic             square_q [NUM_CH];
    logic             square_d [NUM_CH];
`ifdef MFP_AUDIO_ENVELOPE_EN
    logic [PWM_W-1:0] live_q   [NUM_CH];
    logic [PWM_W-1:0] live_d   [NUM_CH];
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= CH_IDLE;
                half_q[c]   <= '0;
                dur_q[c]    <= '0;
                square_q[c] <= 1'b0;
`ifdef MFP_AUDIO_ENVELOPE_EN
                live_q[c]   <= '0;
`endif
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= state_d[c];
                half_q[c]   <= half_d[c];
                dur_q[c]    <= dur_d[c];
                square_q[c] <= square_d[c];
`ifdef MFP_AUDIO_ENVELOPE_EN
                live_q[c]   <= live_d[c];
`endif
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            // NOTE: every combinational output gets a default before any
            // branch, so no path leaves it unassigned and no latch is built.
            state_d[c]  = state_q[c];
            half_d[c]   = half_q[c];
            dur_d[c]    = dur_q[c];
            square_d[c] = square_q[c];
`ifdef MFP_AUDIO_ENVELOPE_EN
            live_d[c]   = live_q[c];
`endif
            if (stop_req[c]) begin
                state_d[c] = CH_IDLE;
            end else if (start_req[c]) begin
                // A start while playing simply restarts the note.
                state_d[c]  = CH_PLAY;
                half_d[c]   = period_q[c] - DIV_W'(1);
                dur_d[c]    = duration_q[c];
                square_d[c] = (period_q[c] != '0);
`ifdef MFP_AUDIO_ENVELOPE_EN
                live_d[c]   = volume_q[c];
`endif
            end else if (state_q[c] == CH_PLAY) begin
                if (period_q[c] == '0) begin
                    // Rest note: hold the square low; a zeroed counter makes a
                    // later non-zero PERIOD toggle on the very next cycle.
                    square_d[c] = 1'b0;
                    half_d[c]   = '0;
                end else if (half_q[c] == '0) begin
                    // PERIOD is sampled only here, so a new value lands at the
                    // next reload rather than cutting the current half-cycle.
                    square_d[c] = ~square_q[c];
                    half_d[c]   = period_q[c] - DIV_W'(1);
                end else begin
                    half_d[c]   = half_q[c] - DIV_W'(1);
                end

                if (tick) begin
                    // A zero duration counter means the note never times out.
                    if (dur_q[c] == DUR_W'(1)) begin
                        state_d[c] = CH_IDLE;
                    end else if (dur_q[c] != '0) begin
                        dur_d[c] = dur_q[c] - DUR_W'(1);
                    end
`ifdef MFP_AUDIO_ENVELOPE_EN
                    if (live_q[c] != '0) begin
                        live_d[c] = live_q[c] - PWM_W'(1);
                    end
`endif
                end
            end
`ifdef MFP_AUDIO_ENVELOPE_EN
            // A VOLUME write also sets the live level so it reads back at once.
            if (wr_hit && (int'(wr_ch) == c) && (wr_reg == REG_VOLUME)) begin
                live_d[c] = HWDATA[PWM_W-1:0];
            end
`endif
        end
    end

    // Volume actually heard (and read back) for each channel.
    logic [PWM_W-1:0] vol_eff [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef MFP_AUDIO_ENVELOPE_EN
            vol_eff[c] = live_q[c];
`else
            vol_eff[c] = volume_q[c];
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Mixer and PWM.
    // -------------------------------------------------------------------------
    logic [S-1:0] mix;
    logic [S-1:0] pwm_cnt;
    logic         busy_any;

    always_comb begin
        mix      = '0;
        busy_any = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (state_q[c] == CH_PLAY) begin
                busy_any = 1'b1;
                if (square_q[c]) begin
                    mix = mix + S'(vol_eff[c]);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read mux: decoded from the address phase, registered into HRDATA.
    // -------------------------------------------------------------------------
    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(HADDR[3:2]) == c) begin
                case (HADDR[1:0])
                    REG_PERIOD:   rd_data[DIV_W-1:0] = period_q[c];
                    REG_DURATION: rd_data[DUR_W-1:0] = duration_q[c];
                    REG_VOLUME:   rd_data[PWM_W-1:0] = vol_eff[c];
                    default:      rd_data[0]         = (state_q[c] == CH_PLAY);
                endcase
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            HRDATA                   <= '0;
            pwm_cnt                  <= '0;
            OUT_audio_pwm_and_enable <= 2'b00;
        end else begin
            HRDATA                   <= rd_data;
            pwm_cnt                  <= pwm_cnt + S'(1);
            OUT_audio_pwm_and_enable <= {busy_any, (pwm_cnt < mix)};
        end
    end

endmodule

// File: tb/tb_mfp_ahb_tone_synth.sv
// -----------------------------------------------------------------------------
// tb_mfp_ahb_tone_synth
//
// Directed scenarios with literal expectations, followed by randomized
// per-cycle AHB traffic. A behavioural model (event times, elapsed-cycle
// arithmetic) predicts HRDATA and the audio outputs on every cycle.
// -----------------------------------------------------------------------------
module tb_mfp_ahb_tone_synth;

    localparam int NCH        = 3;
    localparam int TD         = 10;
    localparam int S          = 10;
    localparam int PWM_PERIOD = 1 << S;
`ifdef MFP_AUDIO_ENVELOPE_EN
    localparam bit ENV = 1'b1;
`else
    localparam bit ENV = 1'b0;
`endif

    logic        hclk    = 1'b0;
    logic        hresetn = 1'b0;
    logic [3:0]  haddr   = '0;
    logic [1:0]  htrans  = '0;
    logic [31:0] hwdata  = '0;
    logic        hwrite  = 1'b0;
    logic        hsel    = 1'b0;
    logic [31:0] hrdata;
    logic [1:0]  audio;

    always #20 hclk = ~hclk;

    mfp_ahb_tone_synth #(
        .NUM_CH   (NCH),
        .DIV_W    (16),
        .DUR_W    (16),
        .PWM_W    (8),
        .TICK_DIV (TD)
    ) dut (
        .HCLK                     (hclk),
        .HRESETn                  (hresetn),
        .HADDR                    (haddr),
        .HTRANS                   (htrans),
        .HWDATA                   (hwdata),
        .HWRITE                   (hwrite),
        .HSEL                     (hsel),
        .HRDATA                   (hrdata),
        .OUT_audio_pwm_and_enable (audio)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model. Time is the number of cycles since reset; ticks and
    // the PWM ramp are pure functions of it. Square edges are kept as absolute
    // cycle numbers of the next toggle.
    // -------------------------------------------------------------------------
    bit          model_ok = 1'b0;
    int          m_cyc;
    bit          m_we_d;
    logic [3:0]  m_addr_d;
    int          m_period [4];
    int          m_dur    [4];
    int          m_vol    [4];
    int          m_live   [4];
    bit          m_play   [4];
    bit          m_sq     [4];
    int          m_next   [4];
    int          m_rem    [4];
    logic [31:0] m_hrdata;
    logic [1:0]  m_out;

    function automatic logic [31:0] model_read(input logic [3:0] a);
        int ch;
        ch = int'(a[3:2]);
        if (ch >= NCH) return 32'd0;
        case (a[1:0])
            2'd0:    return 32'(m_period[ch]);
            2'd1:    return 32'(m_dur[ch]);
            2'd2:    return 32'(ENV ? m_live[ch] : m_vol[ch]);
            default: return {31'd0, m_play[ch]};
        endcase
    endfunction

    task automatic model_step();
        int cur, mix, wc, data;
        bit tick, any, wr;
        if (!hresetn) begin
            model_ok = 1'b1;
            m_cyc = 0; m_we_d = 1'b0; m_addr_d = '0;
            m_hrdata = '0; m_out = 2'b00;
            for (int c = 0; c < 4; c++) begin
                m_period[c] = 0; m_dur[c] = 0; m_vol[c] = 0; m_live[c] = 0;
                m_play[c] = 1'b0; m_sq[c] = 1'b0; m_next[c] = 0; m_rem[c] = 0;
            end
            return;
        end
        cur  = m_cyc;
        tick = (cur % TD) == TD - 1;

        mix = 0; any = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (m_play[c]) begin
                any = 1'b1;
                if (m_sq[c]) mix += ENV ? m_live[c] : m_vol[c];
            end
        end
        m_out    = {any, (cur % PWM_PERIOD) < mix};
        m_hrdata = model_read(haddr);

        wc = int'(m_addr_d[3:2]);
        wr = m_we_d && (wc < NCH);
        for (int c = 0; c < NCH; c++) begin
            bit is_ctrl;
            is_ctrl = wr && (wc == c) && (m_addr_d[1:0] == 2'd3);
            if (is_ctrl && hwdata[1]) begin
                m_play[c] = 1'b0;
            end else if (is_ctrl && hwdata[0]) begin
                m_play[c] = 1'b1;
                m_sq[c]   = (m_period[c] != 0);
                m_next[c] = cur + m_period[c];
                m_rem[c]  = m_dur[c];
                m_live[c] = m_vol[c];
            end else if (m_play[c]) begin
                if (m_period[c] == 0) begin
                    m_sq[c]   = 1'b0;
                    m_next[c] = cur + 1;
                end else if (cur == m_next[c]) begin
                    m_sq[c]   = !m_sq[c];
                    m_next[c] = cur + m_period[c];
                end
                if (tick) begin
                    if (m_rem[c] == 1) m_play[c] = 1'b0;
                    else if (m_rem[c] > 1) m_rem[c]--;
                    if (m_live[c] > 0) m_live[c]--;
                end
            end
        end
        if (wr) begin
            case (m_addr_d[1:0])
                2'd0: m_period[wc] = int'(hwdata[15:0]);
                2'd1: m_dur[wc]    = int'(hwdata[15:0]);
                2'd2: begin
                    data = int'(hwdata[7:0]);
                    m_vol[wc]  = data;
                    m_live[wc] = data;
                end
                default: ;
            endcase
        end

        m_we_d   = hsel && (htrans != 2'b00) && hwrite;
        m_addr_d = haddr;
        m_cyc    = cur + 1;
    endtask

    always @(posedge hclk) model_step();

    // Cycle-by-cycle comparison, sampled mid-cycle.
    always @(negedge hclk) begin
        if (model_ok) begin
            check("cyc_out", {30'd0, audio}, {30'd0, m_out});
            check("cyc_hrdata", hrdata, m_hrdata);
        end
    end

    // -------------------------------------------------------------------------
    // Bus helpers (inputs change 1 time unit after the rising edge).
    // -------------------------------------------------------------------------
    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
        @(posedge hclk); #1;
        hwdata = d; bus_idle();
        @(posedge hclk); #1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
        @(posedge hclk); #1;
        bus_idle();
        d = hrdata;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int cnt_pwm, cnt_en, k;
        bit done;

        // Reset.
        hresetn = 1'b0;
        wait_cycles(3);
        hresetn = 1'b1;
        check("rst_out", {30'd0, audio}, 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        rd(4'h3, d);
        check("rst_ctrl0", d, 32'd0);

        // Tone on ch0: half-period 5, infinite, full volume.
        wr(4'h0, 32'd5);
        wr(4'h1, 32'd0);
        wr(4'h2, 32'd255);
        rd(4'h0, d);
        check("period_rb", d, 32'd5);
        rd(4'h2, d);
        check("volume_rb", d, 32'd255);
        wr(4'h3, 32'h1);
        rd(4'h3, d);
        check("tone_busy", d, 32'd1);
        wait_cycles(1);
        check("tone_enable", {31'd0, audio[1]}, 32'd1);
        cnt_pwm = 0;
        repeat (2 * PWM_PERIOD) begin
            @(negedge hclk);
            cnt_pwm += int'(audio[0]);
        end
        @(posedge hclk); #1;
        check("tone_duty_range", {31'd0, (cnt_pwm >= 250 && cnt_pwm <= 260)}, 32'd1);
        wr(4'h3, 32'h2);
        rd(4'h3, d);
        check("stop_idle", d, 32'd0);
        wait_cycles(2);
        check("stop_out", {30'd0, audio}, 32'd0);

        // Start and stop together: stop wins.
        wr(4'h3, 32'h3);
        rd(4'h3, d);
        check("ctrl3_idle", d, 32'd0);

        // Rest note on ch2.
        wr(4'h8, 32'd0);
        wr(4'h9, 32'd0);
        wr(4'hA, 32'd200);
        wr(4'hB, 32'h1);
        wait_cycles(3);
        cnt_pwm = 0; cnt_en = 0;
        repeat (1100) begin
            @(negedge hclk);
            cnt_pwm += int'(audio[0]);
            cnt_en  += int'(audio[1]);
        end
        @(posedge hclk); #1;
        check("rest_pwm_low", 32'(cnt_pwm), 32'd0);
        check("rest_enable_high", 32'(cnt_en), 32'd1100);
        wr(4'hB, 32'h2);

        // Channel index 3 does not exist with NCH=3.
        wr(4'hC, 32'd7);
        wr(4'hF, 32'h1);
        rd(4'hC, d);
        check("ghost_period", d, 32'd0);
        rd(4'hF, d);
        check("ghost_ctrl", d, 32'd0);
        wait_cycles(2);
        check("ghost_out", {30'd0, audio}, 32'd0);

        // Duration on ch1: 4 ticks of 10 cycles.
        wr(4'h4, 32'd3);
        wr(4'h5, 32'd4);
        wr(4'h6, 32'd10);
        wr(4'h7, 32'h1);
        k = 0; done = 1'b0;
        while (!done && k < 100) begin
            rd(4'h7, d);
            k++;
            if (d[0] == 1'b0) done = 1'b1;
        end
        check("dur_ended", {31'd0, done}, 32'd1);
        check("dur_len_range", {31'd0, (k >= 29 && k <= 42)}, 32'd1);

        // Mixing three channels at full volume with long half-periods.
        for (int c = 0; c < NCH; c++) begin
            wr(4'(c * 4 + 0), 32'd4000);
            wr(4'(c * 4 + 1), 32'd0);
            wr(4'(c * 4 + 2), 32'd255);
        end
        for (int c = 0; c < NCH; c++) wr(4'(c * 4 + 3), 32'h1);
        wait_cycles(3);
        cnt_pwm = 0;
        repeat (PWM_PERIOD) begin
            @(negedge hclk);
            cnt_pwm += int'(audio[0]);
        end
        @(posedge hclk); #1;
        check("mix_duty", 32'(cnt_pwm), 32'd765);
        for (int c = 0; c < NCH; c++) wr(4'(c * 4 + 3), 32'h2);

        // Restart while busy reloads the counters (tracked by the model).
        wr(4'h0, 32'd20);
        wr(4'h1, 32'd3);
        wr(4'h3, 32'h1);
        wait_cycles(15);
        wr(4'h3, 32'h1);
        wait_cycles(50);

        // Volume over time.
        wr(4'h0, 32'd2);
        wr(4'h1, 32'd0);
        wr(4'h2, 32'd5);
        wr(4'h3, 32'h1);
        wait_cycles(80);
        rd(4'h2, d);
        check("env_volume", d, ENV ? 32'd0 : 32'd5);

        // Reset in the middle of a note.
        hresetn = 1'b0;
        wait_cycles(1);
        check("rst_mid_out", {30'd0, audio}, 32'd0);
        wait_cycles(2);
        hresetn = 1'b1;
        check("rst_mid_hrdata", hrdata, 32'd0);
        for (int c = 0; c < NCH; c++) begin
            rd(4'(c * 4 + 3), d);
            check("rst_mid_ctrl", d, 32'd0);
        end
        rd(4'h0, d);
        check("rst_mid_period", d, 32'd0);

        // Randomized per-cycle bus traffic with one reset pulse.
        for (int i = 0; i < 6000; i++) begin
            hsel   = ($urandom_range(0, 3) != 0);
            htrans = 2'($urandom_range(0, 3));
            hwrite = 1'($urandom_range(0, 1));
            haddr  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) hwdata = $urandom;
            else                           hwdata = 32'($urandom_range(0, 12));
            hresetn = !(i >= 3000 && i < 3003);
            @(posedge hclk); #1;
        end
        bus_idle();
        hresetn = 1'b1;
        wait_cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
